// File: rtl/vram_arbiter.sv
// Video RAM port arbiter between the video fetch engine and the Z80 CPU.
// Video owns the odd phases of each character cell inside the display window.
// The CPU is served in every other phase, one access per request.
module vram_arbiter #(
    parameter int unsigned AW = 13,
    parameter int unsigned BW = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [2:0]       phase,
    input  logic             vidActive,
    input  logic [BW-1:0]    vidB,
    input  logic [AW-1:0]    vidA,
    input  logic             cpuReq,
    input  logic             cpuWr,
    input  logic [BW-1:0]    cpuB,
    input  logic [AW-1:0]    cpuA,
    input  logic [7:0]       cpuD,
    output logic [7:0]       cpuQ,
    output logic             cpuWait,
    output logic [BW+AW-1:0] ramA,
    output logic             ramWe,
    output logic [7:0]       ramD,
    input  logic [7:0]       ramQ
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic            wr_q,    wr_d;
    logic [BW-1:0]   bank_q,  bank_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [7:0]      data_q,  data_d;
    logic [7:0]      rdata_q, rdata_d;

    logic video_slot;
    logic free_slot;
    logic grant;

    assign video_slot = phase[0] && vidActive;
    assign free_slot  = !video_slot;
    // Grant is the whole clock, not just the ce edge, so the RAM sees a stable address.
    assign grant      = (state_q == StPend) && free_slot;

    // Next-state logic: request latching, grant completion and release handshake.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (ce && cpuReq) begin
                    wr_d    = cpuWr;
                    bank_d  = cpuB;
                    addr_d  = cpuA;
                    data_d  = cpuD;
                    state_d = StPend;
                end
            end
            StPend: begin
                // Completes even if the CPU has dropped its request meanwhile.
                if (ce && free_slot) begin
                    if (!wr_q) begin
                        rdata_d = ramQ;
                    end
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ce && !cpuReq) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM port mux and CPU handshake outputs.
    always_comb begin
        ramA    = {vidB, vidA};
        ramWe   = 1'b0;
        ramD    = data_q;
        cpuQ    = rdata_q;
        cpuWait = cpuReq && (state_q != StHold);
        if (grant) begin
            ramA = {bank_q, addr_q};
            // Reset in the grant clock must not leak a write to the RAM.
            ramWe = wr_q && ce && !reset;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table plus corner-case sequences.
module tb_vram_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned BW = 2;
    localparam logic [14:0] VA = 15'h7111;  // {vidB=3, vidA=0x1111}
    localparam logic [14:0] CA = 15'h4ABC;  // {cpuB=2, cpuA=0x0ABC}

    logic          clock = 1'b0;
    logic          reset, ce, vidActive, cpuReq, cpuWr, cpuWait, ramWe;
    logic [2:0]    phase;
    logic [BW-1:0] vidB, cpuB;
    logic [AW-1:0] vidA, cpuA;
    logic [7:0]    cpuD, cpuQ, ramD, ramQ;
    logic [14:0]   ramA;

    vram_arbiter #(.AW(AW), .BW(BW)) dut (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .phase     (phase),
        .vidActive (vidActive),
        .vidB      (vidB),
        .vidA      (vidA),
        .cpuReq    (cpuReq),
        .cpuWr     (cpuWr),
        .cpuB      (cpuB),
        .cpuA      (cpuA),
        .cpuD      (cpuD),
        .cpuQ      (cpuQ),
        .cpuWait   (cpuWait),
        .ramA      (ramA),
        .ramWe     (ramWe),
        .ramD      (ramD),
        .ramQ      (ramQ)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, ce;
        logic [2:0]  ph;
        logic        act, req, wr;
        logic [7:0]  d, rq;
        logic        ew, ewe;
        logic [14:0] ea;
        logic [7:0]  ed, eq;
        logic [4:0]  m;  // compare mask: wait, we, addr, wdata, rdata
    } vec_t;

    vec_t tbl[26];
    vec_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(input logic rst, input logic c, input logic [2:0] ph,
                                input logic act, input logic req, input logic wr,
                                input logic [7:0] d, input logic [7:0] rq,
                                input logic ew, input logic ewe, input logic [14:0] ea,
                                input logic [7:0] ed, input logic [7:0] eq);
        vec_t v;
        v.rst = rst; v.ce = c; v.ph = ph; v.act = act; v.req = req; v.wr = wr;
        v.d = d; v.rq = rq; v.ew = ew; v.ewe = ewe; v.ea = ea; v.ed = ed; v.eq = eq;
        v.m = 5'b11111;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one clock of stimulus, queue its expectation, compare before the next edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(posedge clock);
        #1;
        reset = v.rst; ce = v.ce; phase = v.ph; vidActive = v.act;
        cpuReq = v.req; cpuWr = v.wr; cpuD = v.d; ramQ = v.rq;
        sb_q.push_back(v);
        @(negedge clock);
        e = sb_q.pop_front();
        if (e.m[0]) chk("cpuWait", idx, {15'd0, cpuWait}, {15'd0, e.ew});
        if (e.m[1]) chk("ramWe",   idx, {15'd0, ramWe},   {15'd0, e.ewe});
        if (e.m[2]) chk("ramA",    idx, {1'b0, ramA},     {1'b0, e.ea});
        if (e.m[3]) chk("ramD",    idx, {8'd0, ramD},     {8'd0, e.ed});
        if (e.m[4]) chk("cpuQ",    idx, {8'd0, cpuQ},     {8'd0, e.eq});
    endtask

    initial begin
        vec_t v;
        int   pulses;
        bit   seen;

        //          rst ce ph act req wr d      rq     wait we addr ramD   cpuQ
        // Reset while a write is pending in PEND.
        tbl[0]  = mk(0, 1, 0, 1, 1, 1, 8'h77, 8'h00, 1, 0, VA, 8'h00, 8'h00);
        tbl[1]  = mk(0, 1, 1, 1, 1, 1, 8'h77, 8'h00, 1, 0, VA, 8'h77, 8'h00);
        tbl[2]  = mk(1, 1, 2, 1, 1, 1, 8'h77, 8'h00, 1, 0, CA, 8'h77, 8'h00);
        tbl[3]  = mk(1, 1, 3, 1, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h00, 8'h00);
        tbl[4]  = mk(0, 1, 4, 0, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h00, 8'h00);
        // Blanking write.
        tbl[5]  = mk(0, 1, 5, 0, 1, 1, 8'h5A, 8'h00, 1, 0, VA, 8'h00, 8'h00);
        tbl[6]  = mk(0, 1, 6, 0, 1, 1, 8'h5A, 8'h00, 1, 1, CA, 8'h5A, 8'h00);
        tbl[7]  = mk(0, 1, 7, 0, 1, 1, 8'h5A, 8'h00, 0, 0, VA, 8'h5A, 8'h00);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0, 8'h5A, 8'h00, 0, 0, VA, 8'h5A, 8'h00);
        // No latching without ce.
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h5A, 8'h00);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 8'h11, 8'h00, 1, 0, VA, 8'h5A, 8'h00);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 8'h11, 8'h00, 1, 0, VA, 8'h5A, 8'h00);
        // Active-window read deferred past a video phase; one ce-less grant clock.
        tbl[12] = mk(0, 1, 0, 1, 1, 0, 8'h11, 8'hC3, 1, 0, VA, 8'h5A, 8'h00);
        tbl[13] = mk(0, 1, 1, 1, 1, 0, 8'h11, 8'hC3, 1, 0, VA, 8'h11, 8'h00);
        tbl[14] = mk(0, 0, 2, 1, 1, 0, 8'h11, 8'hC3, 1, 0, CA, 8'h11, 8'h00);
        tbl[15] = mk(0, 1, 2, 1, 1, 0, 8'h11, 8'hC3, 1, 0, CA, 8'h11, 8'h00);
        tbl[16] = mk(0, 1, 3, 1, 1, 0, 8'h11, 8'h00, 0, 0, VA, 8'h11, 8'hC3);
        tbl[17] = mk(0, 1, 4, 1, 0, 0, 8'h11, 8'h00, 0, 0, VA, 8'h11, 8'hC3);
        tbl[18] = mk(0, 1, 5, 1, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h11, 8'hC3);
        // Request dropped while PEND: write still lands once, then back to IDLE.
        tbl[19] = mk(0, 1, 6, 1, 1, 1, 8'h3C, 8'h00, 1, 0, VA, 8'h11, 8'hC3);
        tbl[20] = mk(0, 1, 7, 1, 0, 1, 8'h3C, 8'h00, 0, 0, VA, 8'h3C, 8'hC3);
        tbl[21] = mk(0, 1, 0, 1, 0, 1, 8'h3C, 8'h00, 0, 1, CA, 8'h3C, 8'hC3);
        tbl[22] = mk(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h3C, 8'hC3);
        // IDLE reached: a fresh read is accepted and granted at once in blanking.
        tbl[23] = mk(0, 1, 2, 1, 1, 0, 8'h99, 8'h5E, 1, 0, VA, 8'h3C, 8'hC3);
        tbl[24] = mk(0, 1, 3, 0, 1, 0, 8'h99, 8'h5E, 1, 0, CA, 8'h99, 8'hC3);
        tbl[25] = mk(0, 1, 4, 0, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h99, 8'h5E);

        vidB = 2'd3; vidA = 13'h1111; cpuB = 2'd2; cpuA = 13'h0ABC;
        reset = 1'b1; ce = 1'b1; phase = 3'd0; vidActive = 1'b0;
        cpuReq = 1'b0; cpuWr = 1'b0; cpuD = 8'h00; ramQ = 8'h00;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i], i);
        end

        // Continuous CPU traffic in the active window: video keeps every odd phase.
        for (int i = 0; i < 64; i++) begin
            v = mk(0, 1, i[2:0], 1, (i % 6) != 5, i[3], i[7:0], 8'h00,
                   0, 0, VA, 8'h00, 8'h00);
            v.m = i[0] ? 5'b00110 : 5'b00000;
            step(v, 100 + i);
        end
        for (int i = 0; i < 3; i++) begin
            v = mk(0, 1, 3'(i), 0, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'h00, 8'h00);
            v.m = 5'b00000;
            step(v, 200 + i);
        end

        // Held request: exactly one write, WAIT low from grant until release.
        pulses = 0;
        seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = mk(0, 1, 3'(i + 1), 1, 1, 1, 8'hA5, 8'h00, 0, 0, VA, 8'h00, 8'h00);
            v.m = 5'b00000;
            step(v, 300 + i);
            if (seen) chk("wait_after_grant", i, {15'd0, cpuWait}, 16'd0);
            if (ramWe) begin
                pulses++;
                chk("held_wdata", i, {8'd0, ramD}, 16'h00A5);
            end
            seen = seen || (ramWe === 1'b1);
        end
        chk("held_pulses", 0, 16'(pulses), 16'd1);
        v = mk(0, 1, 3'd3, 1, 0, 0, 8'h00, 8'h00, 0, 0, VA, 8'hA5, 8'h00);
        step(v, 400);
        v = mk(0, 1, 3'd4, 1, 1, 0, 8'h00, 8'h00, 1, 0, VA, 8'hA5, 8'h00);
        step(v, 401);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
